// File: rtl/pc_gen.sv
// pc_gen -- instruction fetch program-counter generator.
//
// Produces the fetch address for instruction memory. After reset it spends
// one BOOT cycle with no fetch request, then enters RUN. In RUN the PC moves
// only when it is not stalled and the memory grants the request (an
// "advance"). The next PC comes from the control-transfer type of the
// instruction currently at pc_o. A target that is not 4-byte aligned
// redirects to TRAP_VECTOR, latches the faulting PC into mepc_o and raises
// a one-cycle misalign_o pulse.
//
// Ports
//   clk             clock; all state updates on its rising edge
//   reset           synchronous, active-high reset
//   stall_i         pipeline stall; freezes PC, counter and mepc
//   opcode_i        opcode of the instruction at pc_o
//   branch_taken_i  branch comparator result for the instruction at pc_o
//   imm_i           sign-extended immediate for the instruction at pc_o
//   rs1_i           rs1 operand used by JALR
//   imem_req_o      fetch request to instruction memory
//   imem_gnt_i      instruction memory accepts the current request
//   pc_o            current fetch address
//   pc_plus4_o      pc_o + 4, link value for JAL/JALR
//   misalign_o      one-cycle pulse after a misaligned control transfer
//   mepc_o          pc_o of the instruction that raised the last misalign
//   instr_cnt_o     number of advances since reset (wraps)
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | first cycle after reset; no fetch request, grants ignored
// RUN   | normal fetch; request whenever not stalled, advance on grant

module pc_gen #(
   parameter int unsigned       XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic [6:0]        opcode_i,
   input  logic              branch_taken_i,
   input  logic [XLEN-1:0]   imm_i,
   input  logic [XLEN-1:0]   rs1_i,
   output logic              imem_req_o,
   input  logic              imem_gnt_i,
   output logic [XLEN-1:0]   pc_o,
   output logic [XLEN-1:0]   pc_plus4_o,
   output logic              misalign_o,
   output logic [XLEN-1:0]   mepc_o,
   output logic [XLEN-1:0]   instr_cnt_o
);

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   mepc_q;
   logic [XLEN-1:0]   cnt_q;
   logic              misalign_q;

   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   pc_rel;
   logic [XLEN-1:0]   jalr_sum;
   logic [XLEN-1:0]   target;
   logic              target_misaligned;
   logic              advance;

   // All adders are XLEN wide, so carries out of the top bit are dropped
   // and the PC wraps naturally.
   assign pc_plus4 = pc_q + XLEN'(4);
   assign pc_rel   = pc_q + imm_i;
   assign jalr_sum = rs1_i + imm_i;

   always_comb begin
      target = pc_plus4;
      if (opcode_i == OPC_JAL) begin
         target = pc_rel;
      end else if (opcode_i == OPC_BRANCH && branch_taken_i) begin
         target = pc_rel;
      end else if (opcode_i == OPC_JALR) begin
         target = jalr_sum & ~XLEN'(1);
      end
   end

   // pc_q stays word aligned, so the pc+4 path can never trip this check.
   assign target_misaligned = (target[1:0] != 2'b00);

   // Grants seen in BOOT or while stalled are dropped here.
   assign advance = (state_q == ST_RUN) && !stall_i && imem_gnt_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         mepc_q     <= '0;
         cnt_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         // misalign is a single-cycle pulse regardless of what follows
         misalign_q <= 1'b0;
         case (state_q)
            ST_BOOT: begin
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (advance) begin
                  cnt_q <= cnt_q + XLEN'(1);
                  if (target_misaligned) begin
                     pc_q       <= TRAP_VECTOR;
                     mepc_q     <= pc_q;
                     misalign_q <= 1'b1;
                  end else begin
                     pc_q <= target;
                  end
               end
            end
            default: begin
               state_q <= ST_BOOT;
            end
         endcase
      end
   end

   // The request follows stall_i within the cycle so memory never sees a
   // request that the PC logic would then refuse to act on.
   assign imem_req_o  = (state_q == ST_RUN) && !stall_i;
   assign pc_o        = pc_q;
   assign pc_plus4_o  = pc_plus4;
   assign misalign_o  = misalign_q;
   assign mepc_o      = mepc_q;
   assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- self-checking bench for pc_gen (default parameters).
// A behavioural model tracks pc, count, mepc, misalign and boot status from
// the inputs applied at each rising edge; DUT outputs are compared 1 time
// unit after the edge.

module tb_pc_gen;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   localparam logic [6:0] OP_ADDI = 7'h13;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i;
   logic [6:0]  opcode_i;
   logic        branch_taken_i;
   logic [31:0] imm_i;
   logic [31:0] rs1_i;
   logic        imem_req_o;
   logic        imem_gnt_i;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic        misalign_o;
   logic [31:0] mepc_o;
   logic [31:0] instr_cnt_o;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk            (clk),
      .reset          (reset),
      .stall_i        (stall_i),
      .opcode_i       (opcode_i),
      .branch_taken_i (branch_taken_i),
      .imm_i          (imm_i),
      .rs1_i          (rs1_i),
      .imem_req_o     (imem_req_o),
      .imem_gnt_i     (imem_gnt_i),
      .pc_o           (pc_o),
      .pc_plus4_o     (pc_plus4_o),
      .misalign_o     (misalign_o),
      .mepc_o         (mepc_o),
      .instr_cnt_o    (instr_cnt_o)
   );

   // reference model state
   logic [31:0] m_pc   = RV;
   logic [31:0] m_cnt  = '0;
   logic [31:0] m_mepc = '0;
   logic        m_mis  = 1'b0;
   logic        m_boot = 1'b1;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_target(input logic [31:0] pc);
      case (opcode_i)
         OP_BR:   return branch_taken_i ? pc + imm_i : pc + 32'd4;
         OP_JAL:  return pc + imm_i;
         OP_JALR: return (rs1_i + imm_i) & 32'hFFFF_FFFE;
         default: return pc + 32'd4;
      endcase
   endfunction

   task automatic model_edge();
      logic [31:0] t;
      if (reset) begin
         m_pc = RV; m_cnt = '0; m_mepc = '0; m_mis = 1'b0; m_boot = 1'b1;
      end else begin
         m_mis = 1'b0;
         if (m_boot) begin
            m_boot = 1'b0;
         end else if (!stall_i && imem_gnt_i) begin
            t = ref_target(m_pc);
            m_cnt = m_cnt + 32'd1;
            if (t % 4 != 0) begin
               m_mepc = m_pc;
               m_pc   = TV;
               m_mis  = 1'b1;
            end else begin
               m_pc = t;
            end
         end
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check({tag, ".pc"},    pc_o,        m_pc);
      check({tag, ".pc4"},   pc_plus4_o,  m_pc + 32'd4);
      check({tag, ".cnt"},   instr_cnt_o, m_cnt);
      check({tag, ".mepc"},  mepc_o,      m_mepc);
      check({tag, ".mis"},   {31'd0, misalign_o}, {31'd0, m_mis});
      check({tag, ".req"},   {31'd0, imem_req_o}, {31'd0, (!m_boot && !stall_i)});
   endtask

   task automatic drive(input logic rst, input logic st, input logic g, input logic [6:0] op,
                        input logic tk, input logic [31:0] im, input logic [31:0] rs);
      reset = rst; stall_i = st; imem_gnt_i = g; opcode_i = op;
      branch_taken_i = tk; imm_i = im; rs1_i = rs;
   endtask

   task automatic goto_pc(input logic [31:0] dest);
      drive(0, 0, 1, OP_JAL, 0, dest - m_pc, 0);
      step("goto");
   endtask

   initial begin
      logic [31:0] s_pc, s_cnt;
      int sel;
      int imm_v;

      drive(1, 0, 0, OP_ADDI, 0, 0, 0);
      step("rst0");
      step("rst1");
      check("rst_pc_const", pc_o, RV);

      // straight-line fetch; first edge after reset is the BOOT cycle
      drive(0, 0, 1, OP_ADDI, 0, 0, 0);
      step("boot");
      check("boot_pc_const", pc_o, 32'h0);
      check("boot_cnt_const", instr_cnt_o, 32'h0);
      step("seq1");
      step("seq2");
      step("seq3");
      check("seq_pc_const", pc_o, 32'hC);
      check("seq_cnt_const", instr_cnt_o, 32'd3);

      // conditional branch taken / not taken
      goto_pc(32'h40);
      check("goto40", pc_o, 32'h40);
      drive(0, 0, 1, OP_BR, 1, 32'hFFFF_FFF8, 0);
      step("br_taken");
      check("br_taken_const", pc_o, 32'h38);
      goto_pc(32'h40);
      drive(0, 0, 1, OP_BR, 0, 32'hFFFF_FFF8, 0);
      step("br_not");
      check("br_not_const", pc_o, 32'h44);

      // JALR with bit 0 cleared, then a misaligned JALR
      goto_pc(32'h40);
      drive(0, 0, 1, OP_JALR, 0, 32'd4, 32'h1001);
      step("jalr_ok");
      check("jalr_ok_const", pc_o, 32'h1004);
      check("jalr_ok_mis", {31'd0, misalign_o}, 32'd0);
      goto_pc(32'h40);
      drive(0, 0, 1, OP_JALR, 0, 32'd4, 32'h1002);
      step("jalr_trap");
      check("trap_pc_const", pc_o, 32'h100);
      check("trap_mepc_const", mepc_o, 32'h40);
      check("trap_mis_const", {31'd0, misalign_o}, 32'd1);
      drive(0, 0, 1, OP_ADDI, 0, 0, 0);
      step("trap_after");
      check("trap_pulse_end", {31'd0, misalign_o}, 32'd0);

      // missing grant, then stall with grant
      s_pc = m_pc; s_cnt = m_cnt;
      drive(0, 0, 0, OP_ADDI, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step("nognt");
         check("nognt_pc_frozen", pc_o, s_pc);
         check("nognt_cnt_frozen", instr_cnt_o, s_cnt);
      end
      drive(0, 0, 1, OP_ADDI, 0, 0, 0);
      step("gnt_release");
      check("gnt_release_pc", pc_o, s_pc + 32'd4);
      check("gnt_release_cnt", instr_cnt_o, s_cnt + 32'd1);
      s_pc = m_pc; s_cnt = m_cnt;
      drive(0, 1, 1, OP_JAL, 0, 32'h200, 0);
      for (int i = 0; i < 3; i++) begin
         step("stall");
         check("stall_pc_frozen", pc_o, s_pc);
         check("stall_cnt_frozen", instr_cnt_o, s_cnt);
         check("stall_req_low", {31'd0, imem_req_o}, 32'd0);
      end
      drive(0, 0, 1, OP_ADDI, 0, 0, 0);
      step("stall_release");
      check("stall_release_pc", pc_o, s_pc + 32'd4);

      // address wrap, then reset during the misalign pulse
      goto_pc(32'hFFFF_FFFC);
      drive(0, 0, 1, OP_ADDI, 0, 0, 0);
      step("wrap");
      check("wrap_pc_const", pc_o, 32'h0);
      goto_pc(32'h40);
      drive(0, 0, 1, OP_BR, 1, 32'h6, 0);
      step("br_trap");
      check("br_trap_mis", {31'd0, misalign_o}, 32'd1);
      drive(1, 0, 1, OP_JAL, 0, 32'h20, 0);
      step("rst_in_pulse");
      check("rst_pulse_mis", {31'd0, misalign_o}, 32'd0);
      check("rst_pulse_pc", pc_o, RV);
      check("rst_pulse_mepc", mepc_o, 32'h0);

      // randomized traffic
      drive(0, 0, 1, OP_ADDI, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         sel   = $urandom_range(0, 4);
         imm_v = ($urandom_range(0, 255) - 128) * 4;
         if ($urandom_range(0, 7) == 0) imm_v = imm_v + $urandom_range(1, 3);
         reset          = ($urandom_range(0, 99) < 2);
         stall_i        = ($urandom_range(0, 99) < 20);
         imem_gnt_i     = ($urandom_range(0, 99) < 75);
         branch_taken_i = $urandom_range(0, 1) == 1;
         case (sel)
            0: opcode_i = OP_ADDI;
            1: opcode_i = OP_BR;
            2: opcode_i = OP_JAL;
            3: opcode_i = OP_JALR;
            default: opcode_i = 7'($urandom);
         endcase
         imm_i = imm_v;
         rs1_i = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) rs1_i = rs1_i | 32'($urandom_range(1, 3));
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, address/data width in bits.
REQ-002 The block SHALL expose parameter RESET_VECTOR, default 32'h0000_0000, first fetch address.
REQ-003 The block SHALL expose parameter TRAP_VECTOR, default 32'h0000_0100, redirect address on misaligned target.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall_i  input  1  pipeline stall; high freezes PC and counter.
REQ-007 opcode_i  input  7  opcode of the instruction at pc_o.
REQ-008 branch_taken_i  input  1  branch comparator result for the instruction at pc_o.
REQ-009 imm_i  input  XLEN  sign-extended immediate (SB, UJ or I type) for the instruction at pc_o.
REQ-010 rs1_i  input  XLEN  rs1 operand for JALR.
REQ-011 imem_req_o  output  1  fetch request to instruction memory.
REQ-012 imem_gnt_i  input  1  instruction memory accepts the current request.
REQ-013 pc_o  output  XLEN  current fetch address, also drives instruction memory.
REQ-014 pc_plus4_o  output  XLEN  pc_o + 4, link value for JAL/JALR.
REQ-015 misalign_o  output  1  one-cycle pulse on misaligned control-transfer target.
REQ-016 mepc_o  output  XLEN  pc_o of the instruction that raised the last misalign.
REQ-017 instr_cnt_o  output  XLEN  count of accepted fetches (advances of pc_o).

Function
REQ-018 The block SHALL implement states BOOT and RUN; BOOT holds imem_req_o=0 for exactly one cycle, then the block moves to RUN unconditionally.
REQ-019 In RUN, imem_req_o SHALL be 1 whenever stall_i=0, and 0 while stall_i=1.
REQ-020 An advance SHALL occur on a rising edge where state=RUN, stall_i=0 and imem_gnt_i=1; otherwise pc_o, instr_cnt_o and mepc_o hold.
REQ-021 The next PC on an advance SHALL be selected from opcode_i: 7'b1100011 with branch_taken_i=1 -> pc_o+imm_i; 7'b1101111 (JAL) -> pc_o+imm_i; 7'b1100111 (JALR) -> (rs1_i+imm_i) with bit 0 cleared; any other opcode, or branch not taken -> pc_o+4.
REQ-022 All additions SHALL be modulo 2^XLEN; carry out discarded, wrap from all-ones to zero is legal.
REQ-023 If the selected target has bits [1:0] != 2'b00 on an advance, pc_o SHALL load TRAP_VECTOR, mepc_o SHALL load the old pc_o, and misalign_o SHALL be 1 for the following cycle only.
REQ-024 pc+4 fall-through SHALL never raise misalign; pc_o is kept 4-byte aligned.
REQ-025 instr_cnt_o SHALL increment by 1 on every advance, including a trapping one, and wrap modulo 2^XLEN.
REQ-026 pc_plus4_o SHALL be combinational pc_o+4, valid every cycle.
REQ-027 A grant arriving while stall_i=1 or in BOOT SHALL be ignored.
REQ-028 Priority per edge SHALL be: reset > stall_i > missing grant > misalign trap > normal target.

Reset
REQ-029 While reset=1 at a rising edge: pc_o=RESET_VECTOR, state=BOOT, instr_cnt_o=0, mepc_o=0, misalign_o=0, imem_req_o=0.
REQ-030 Reset asserted mid-operation (including during stall or the trap pulse cycle) SHALL take effect on that edge and discard any pending redirect.
REQ-031 The first advance after reset deassertion SHALL occur no earlier than the second rising edge (one BOOT cycle).

Verification
REQ-032 Reset, then gnt=1, opcode=7'h13 for 4 cycles -> pc_o 0,0,4,8,12 (BOOT cycle first); instr_cnt_o=3 after the third advance.
REQ-033 pc_o=32'h40, opcode=7'b1100011, branch_taken_i=1, imm=-8 -> pc_o=32'h38; same with branch_taken_i=0 -> 32'h44.
REQ-034 pc_o=32'h40, JALR, rs1=32'h1001, imm=4 -> pc_o=32'h1004 (bit 0 cleared), no misalign; rs1=32'h1002 -> pc_o=32'h100, mepc_o=32'h40, misalign_o high one cycle.
REQ-035 gnt=0 for 3 cycles then 1, or stall_i=1 for 3 cycles with gnt=1 -> pc_o and instr_cnt_o frozen throughout; single advance after release; imem_req_o=0 during stall.
REQ-036 pc_o=32'hFFFF_FFFC, opcode=7'h13 -> pc_o=32'h0 (wrap); reset asserted during misalign_o pulse -> misalign_o=0 and pc_o=RESET_VECTOR next cycle.
